// File: rtl/audio_sample_if.sv
// Sample-in / packet-out bundle between the PCM source, the slot scheduler and the
// audio sample packet builder.
interface audio_sample_if #(
   parameter int BIT_WIDTH = 24
);
   logic                       sample_valid;
   logic [BIT_WIDTH-1:0]       sample_left;
   logic [BIT_WIDTH-1:0]       sample_right;
   logic                       packet_take;
   logic                       packet_pending;
   logic                       packet_full;
   logic [7:0]                 frame_counter;
   logic [3:0][1:0][23:0]      audio_sample_word;
   logic [3:0]                 audio_sample_word_present;
   logic                       overflow;

   modport master (
      output sample_valid, sample_left, sample_right, packet_take,
      input  packet_pending, packet_full, frame_counter,
             audio_sample_word, audio_sample_word_present, overflow
   );

   modport slave (
      input  sample_valid, sample_left, sample_right, packet_take,
      output packet_pending, packet_full, frame_counter,
             audio_sample_word, audio_sample_word_present, overflow
   );
endinterface

// File: rtl/audio_sample_buffer.sv
// Stereo PCM FIFO that hands up to four samples per granted packet slot to the
// packet builder, together with the IEC 60958 frame index of subpacket 0.
module audio_sample_buffer #(
   parameter int DEPTH     = 8,
   parameter int BIT_WIDTH = 24
) (
   input  logic          clk_pixel,
   input  logic          reset,
   audio_sample_if.slave bus
);
   localparam int PW = $clog2(DEPTH);

   logic [23:0]           mem_l [DEPTH];
   logic [23:0]           mem_r [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW:0]           count;
   logic [7:0]            frame_cnt;

   logic [7:0]            frame_q;
   logic [3:0][1:0][23:0] word_q;
   logic [3:0]            present_q;
   logic                  overflow_q;

   logic [2:0]            n_pop;
   logic [PW:0]           count_after_pop;
   logic                  accept;
   logic [8:0]            frame_sum;
   logic [23:0]           left_j;
   logic [23:0]           right_j;

   // Pop is decided on the pre-push count, so a same-cycle push never appears in the packet.
   always_comb begin
      n_pop = 3'd0;
      if (bus.packet_take) begin
         n_pop = (count >= (PW+1)'(4)) ? 3'd4 : 3'(count);
      end
      count_after_pop = count - (PW+1)'(n_pop);
      accept          = bus.sample_valid && (count_after_pop < (PW+1)'(DEPTH));
      frame_sum       = {1'b0, frame_cnt} + 9'(n_pop);
      left_j          = 24'(bus.sample_left)  << (24 - BIT_WIDTH);
      right_j         = 24'(bus.sample_right) << (24 - BIT_WIDTH);
   end

   always_ff @(posedge clk_pixel) begin
      if (accept) begin
         mem_l[wr_ptr] <= left_j;
         mem_r[wr_ptr] <= right_j;
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         frame_cnt  <= 8'd0;
         frame_q    <= 8'd0;
         word_q     <= '0;
         present_q  <= 4'b0000;
         overflow_q <= 1'b0;
      end else begin
         if (bus.packet_take) begin
            frame_q   <= frame_cnt;
            frame_cnt <= (frame_sum >= 9'd192) ? 8'(frame_sum - 9'd192) : frame_sum[7:0];
            for (int i = 0; i < 4; i++) begin
               if (3'(i) < n_pop) begin
                  word_q[i][0] <= mem_l[rd_ptr + PW'(i)];
                  word_q[i][1] <= mem_r[rd_ptr + PW'(i)];
                  present_q[i] <= 1'b1;
               end else begin
                  word_q[i]    <= '0;
                  present_q[i] <= 1'b0;
               end
            end
            rd_ptr <= rd_ptr + PW'(n_pop);
         end
         if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
         end else if (bus.sample_valid) begin
            overflow_q <= 1'b1;
         end
         count <= count_after_pop + (PW+1)'(accept);
      end
   end

   assign bus.packet_pending            = (count != '0);
   assign bus.packet_full               = (count >= (PW+1)'(4));
   assign bus.frame_counter             = frame_q;
   assign bus.audio_sample_word         = word_q;
   assign bus.audio_sample_word_present = present_q;
   assign bus.overflow                  = overflow_q;
endmodule

// File: tb/tb_audio_sample_buffer.sv
// Randomized scoreboard bench for audio_sample_buffer against a queue-based model.
module tb_audio_sample_buffer;
   localparam int DEPTH = 8;

   logic clk_pixel = 1'b0;
   logic reset;
   always #5 clk_pixel = ~clk_pixel;

   audio_sample_if #(.BIT_WIDTH(24)) bus ();
   audio_sample_if #(.BIT_WIDTH(16)) bus16 ();

   audio_sample_buffer #(.DEPTH(DEPTH), .BIT_WIDTH(24)) dut (
      .clk_pixel(clk_pixel), .reset(reset), .bus(bus));
   audio_sample_buffer #(.DEPTH(DEPTH), .BIT_WIDTH(16)) dut16 (
      .clk_pixel(clk_pixel), .reset(reset), .bus(bus16));

   typedef struct packed {
      logic [3:0]            present;
      logic [7:0]            frame;
      logic [3:0][1:0][23:0] words;
   } pkt_t;

   pkt_t        exp_q[$];
   logic [47:0] model_q[$];
   int          model_frame;
   bit          model_ovf;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(string name, logic [191:0] act, logic [191:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Model: FIFO queue of {left,right}; frame index advances by number of samples taken.
   task automatic step(bit v, bit take);
      logic [23:0] l;
      logic [23:0] r;
      logic [47:0] s;
      int          n;
      pkt_t        p;
      l = 24'($urandom);
      r = 24'($urandom);
      bus.sample_valid = v;
      bus.sample_left  = l;
      bus.sample_right = r;
      bus.packet_take  = take;
      if (take) begin
         n = (model_q.size() >= 4) ? 4 : model_q.size();
         p = '0;
         p.frame = 8'(model_frame);
         for (int i = 0; i < n; i++) begin
            s = model_q.pop_front();
            p.words[i][0] = s[47:24];
            p.words[i][1] = s[23:0];
            p.present[i]  = 1'b1;
         end
         model_frame = (model_frame + n) % 192;
         exp_q.push_back(p);
      end
      if (v) begin
         if (model_q.size() < DEPTH) model_q.push_back({l, r});
         else model_ovf = 1'b1;
      end
      @(posedge clk_pixel);
      #1;
      bus.sample_valid = 1'b0;
      bus.packet_take  = 1'b0;
      chk("pending", bus.packet_pending, model_q.size() != 0);
      chk("full", bus.packet_full, model_q.size() >= 4);
      chk("overflow", bus.overflow, model_ovf);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.sample_valid = 1'b0;
      bus.packet_take  = 1'b0;
      repeat (2) @(posedge clk_pixel);
      #1;
      reset = 1'b0;
      model_q.delete();
      model_frame = 0;
      model_ovf   = 1'b0;
      chk("drain_before_reset", exp_q.size(), 0);
      exp_q.delete();
      chk("rst_present", bus.audio_sample_word_present, 4'b0000);
      chk("rst_frame", bus.frame_counter, 8'd0);
      chk("rst_words", bus.audio_sample_word, '0);
      chk("rst_overflow", bus.overflow, 1'b0);
      chk("rst_pending", bus.packet_pending, 1'b0);
      chk("rst_full", bus.packet_full, 1'b0);
   endtask

   // Monitor: each accepted packet slot produces registered outputs one cycle later.
   initial begin
      pkt_t p;
      forever begin
         @(posedge clk_pixel);
         if (bus.packet_take && !reset) begin
            #1;
            if (exp_q.size() == 0) begin
               chk("unexpected_packet", 1, 0);
            end else begin
               p = exp_q.pop_front();
               chk("present", bus.audio_sample_word_present, p.present);
               chk("frame_counter", bus.frame_counter, p.frame);
               chk("words", bus.audio_sample_word, p.words);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.sample_valid = 1'b0; bus.sample_left = '0; bus.sample_right = '0; bus.packet_take = 1'b0;
      bus16.sample_valid = 1'b0; bus16.sample_left = '0; bus16.sample_right = '0; bus16.packet_take = 1'b0;
      @(posedge clk_pixel);
      #1;
      do_reset();

      // 3 pushes then take; 4 pushes then two takes (second empty)
      repeat (3) step(1, 0);
      step(0, 1);
      repeat (4) step(1, 0);
      step(0, 1);
      step(0, 1);

      // walk frame counter to 190, then wrap through 192
      while (model_frame != 190) begin
         step(1, 0);
         step(0, 1);
      end
      repeat (4) step(1, 0);
      step(0, 1);
      step(1, 0);
      step(0, 1);

      // overflow on the ninth push into a full FIFO
      repeat (DEPTH + 1) step(1, 0);
      step(0, 1);
      step(0, 1);
      step(0, 1);

      // full FIFO with simultaneous take and push: push accepted, no overflow
      do_reset();
      repeat (DEPTH) step(1, 0);
      step(1, 1);
      step(0, 1);
      step(0, 1);

      // 16-bit instance: left-justification into the 24-bit word
      bus16.sample_valid = 1'b1;
      bus16.sample_left  = 16'h8001;
      bus16.sample_right = 16'h7fff;
      @(posedge clk_pixel); #1;
      bus16.sample_valid = 1'b0;
      bus16.packet_take  = 1'b1;
      @(posedge clk_pixel); #1;
      bus16.packet_take  = 1'b0;
      chk("w16_left", bus16.audio_sample_word[0][0], 24'h800100);
      chk("w16_right", bus16.audio_sample_word[0][1], 24'h7fff00);
      chk("w16_present", bus16.audio_sample_word_present, 4'b0001);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 25));
      end

      // reset mid-fill after a nonzero packet
      do_reset();
      repeat (2) step(1, 0);
      step(0, 1);
      repeat (3) step(1, 0);
      do_reset();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_pixel);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
